// File: rtl/trng_pkg.sv
// Shared types and default parameters for the TRNG sampler slice.
// Optional health test is enabled with the TRNG_RCT_EN macro.
package trng_pkg;

    typedef enum logic {
        VN_IDLE       = 1'b0,
        VN_HAVE_FIRST = 1'b1
    } vn_state_e;

    localparam int unsigned TRNG_WIDTH       = 8;
    localparam int unsigned TRNG_SYNC_STAGES = 2;
    localparam int unsigned TRNG_RCT_LIMIT   = 32;

endpackage

// File: rtl/bit_sync.sv
// Multi-flop synchronizer for a single asynchronous bit.
// Async active-high reset clears every stage.
module bit_sync
    import trng_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = TRNG_SYNC_STAGES
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) sync_q <= '0;
        else       sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
    end

    assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/trng_sampler.sv
// Samples a ring-oscillator bit on divider toggles, Von Neumann debiases it and packs words.
// Define TRNG_RCT_EN to add the sticky repetition-count health test.
module trng_sampler
    import trng_pkg::*;
#(
    parameter int unsigned WIDTH       = TRNG_WIDTH,
    parameter int unsigned SYNC_STAGES = TRNG_SYNC_STAGES,
    parameter int unsigned RCT_LIMIT   = TRNG_RCT_LIMIT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sample_tick,
    input  logic             raw_bit,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             overrun,
    output logic             rct_fail
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] FULL = CW'(WIDTH);

    logic             tick_q;
    logic             s_bit;
    logic             ev;
    vn_state_e        vn_q, vn_d;
    logic             first_q, first_d;
    logic             db_valid, db_bit;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [CW-1:0]    count_q, count_d;
    logic             valid_q, valid_d;
    logic             ovr_q, ovr_d;
    logic             xfer;
    logic             block;

    bit_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk_i (clk),
        .rst_i (rst),
        .d_i   (raw_bit),
        .q_o   (s_bit)
    );

    assign ev = sample_tick ^ tick_q;

    always_comb begin
        vn_d     = vn_q;
        first_d  = first_q;
        db_valid = 1'b0;
        db_bit   = first_q;
        if (ev) begin
            unique case (vn_q)
                VN_IDLE: begin
                    first_d = s_bit;
                    vn_d    = VN_HAVE_FIRST;
                end
                VN_HAVE_FIRST: begin
                    db_valid = (s_bit != first_q);
                    vn_d     = VN_IDLE;
                end
                default: vn_d = VN_IDLE;
            endcase
        end
    end

    // A full word moves out in the same cycle a new bit lands, so the bit starts the next word.
    always_comb begin
        shift_d = shift_q;
        data_d  = data_q;
        count_d = count_q;
        valid_d = valid_q;
        ovr_d   = 1'b0;
        xfer    = (count_q == FULL) && (!valid_q || out_ready) && !block;
        if (xfer) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            count_d = '0;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
        if (db_valid) begin
            if (xfer || (count_q != FULL)) begin
                shift_d = {shift_q[WIDTH-2:0], db_bit};
                count_d = xfer ? CW'(1) : count_q + 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_q  <= 1'b0;
            vn_q    <= VN_IDLE;
            first_q <= 1'b0;
            shift_q <= '0;
            data_q  <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            tick_q  <= sample_tick;
            vn_q    <= vn_d;
            first_q <= first_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            count_q <= count_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

`ifdef TRNG_RCT_EN
    localparam int unsigned RW = $clog2(RCT_LIMIT + 1);

    logic [RW-1:0] rct_q, rct_d;
    logic          prev_q;
    logic          fail_q, fail_d;

    always_comb begin
        rct_d  = rct_q;
        fail_d = fail_q;
        if (ev) begin
            if (s_bit != prev_q)              rct_d = RW'(1);
            else if (rct_q != RW'(RCT_LIMIT)) rct_d = rct_q + 1'b1;
            if (rct_d == RW'(RCT_LIMIT))      fail_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rct_q  <= '0;
            prev_q <= 1'b0;
            fail_q <= 1'b0;
        end else begin
            rct_q  <= rct_d;
            prev_q <= ev ? s_bit : prev_q;
            fail_q <= fail_d;
        end
    end

    assign block    = fail_q;
    assign rct_fail = fail_q;
`else
    assign block    = 1'b0;
    assign rct_fail = 1'b0;
`endif

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_trng_sampler.sv
// Self-checking bench for trng_sampler: vector table plus scoreboarded corner sequences.
module tb_trng_sampler;

    logic       clk = 1'b0;
    logic       rst;
    logic       sample_tick;
    logic       raw_bit;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       overrun;
    logic       rct_fail;

    trng_sampler #(.WIDTH(8), .SYNC_STAGES(2), .RCT_LIMIT(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .sample_tick (sample_tick),
        .raw_bit     (raw_bit),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .overrun     (overrun),
        .rct_fail    (rct_fail)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          npairs;
        logic [31:0] bits;
        logic [7:0]  exp;
    } vec_t;

    vec_t       vecs[5];
    logic [7:0] exp_q[$];
    int         tests = 0;
    int         fails = 0;
    int         valid_cycles = 0;
    int         ovr_cycles = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor the cycle about to be clocked, then advance to the next negedge.
    task automatic tick();
        if (!rst) begin
            if (out_valid) valid_cycles++;
            if (overrun)   ovr_cycles++;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("spurious_word", {31'd0, out_valid}, 32'd0);
                else                   check("word", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
            end
        end
        @(negedge clk);
    endtask

    task automatic send_sample(input logic b);
        raw_bit = b;
        repeat (3) tick();
        sample_tick = ~sample_tick;
        tick();
    endtask

    task automatic send_pair(input logic a, input logic b);
        send_sample(a);
        send_sample(b);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            tick();
            n++;
        end
        repeat (3) tick();
        check({name, "_drained"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] b;
        vecs[0] = '{8,  32'h9A56_0000, 8'hB1};
        vecs[1] = '{12, 32'h33AA_AAAA, 8'hFF};
        vecs[2] = '{8,  32'h5555_0000, 8'h00};
        vecs[3] = '{8,  32'h9999_0000, 8'hAA};
        vecs[4] = '{16, 32'h7878_7878, 8'h55};

        rst = 1'b1; sample_tick = 1'b0; raw_bit = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        repeat (2) tick();
        check("rst_data",     {24'd0, out_data}, 32'd0);
        check("rst_valid",    {31'd0, out_valid}, 32'd0);
        check("rst_overrun",  {31'd0, overrun}, 32'd0);
        check("rst_rct_fail", {31'd0, rct_fail}, 32'd0);
        rst = 1'b0;
        tick();

        for (int v = 0; v < 5; v++) begin
            out_ready = 1'b1;
            valid_cycles = 0;
            exp_q.push_back(vecs[v].exp);
            b = vecs[v].bits;
            for (int p = 0; p < vecs[v].npairs; p++) begin
                send_pair(b[31-2*p], b[30-2*p]);
            end
            drain($sformatf("vec%0d", v));
            check($sformatf("vec%0d_valid_cycles", v), valid_cycles, 1);
        end

        // Reset mid-word: 5 debiased zeros must not leak into the next word.
        for (int i = 0; i < 5; i++) send_pair(1'b0, 1'b1);
        send_sample(1'b1);
        rst = 1'b1;
        tick();
        check("midrst_data",    {24'd0, out_data}, 32'd0);
        check("midrst_valid",   {31'd0, out_valid}, 32'd0);
        check("midrst_overrun", {31'd0, overrun}, 32'd0);
        sample_tick = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        valid_cycles = 0;
        exp_q.push_back(8'hFF);
        for (int i = 0; i < 8; i++) send_pair(1'b1, 1'b0);
        drain("midrst");
        check("midrst_valid_cycles", valid_cycles, 1);

        // Backpressure and overrun.
        out_ready = 1'b0;
        ovr_cycles = 0;
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'hFF);
        for (int i = 0; i < 16; i++) send_pair(1'b1, 1'b0);
        repeat (3) tick();
        check("bp_valid", {31'd0, out_valid}, 32'd1);
        check("bp_data",  {24'd0, out_data}, 32'hFF);
        check("bp_count", {28'd0, dut.count_q}, 32'd8);
        check("bp_shift", {24'd0, dut.shift_q}, 32'hFF);
        check("bp_no_overrun_yet", ovr_cycles, 0);
        send_pair(1'b1, 1'b0);
        repeat (3) tick();
        check("bp_overrun_cycles", ovr_cycles, 1);
        check("bp_shift_kept", {24'd0, dut.shift_q}, 32'hFF);
        out_ready = 1'b1;
        tick();
        check("bp_second_valid", {31'd0, out_valid}, 32'd1);
        check("bp_second_data",  {24'd0, out_data}, 32'hFF);
        check("bp_count_clear",  {28'd0, dut.count_q}, 32'd0);
        drain("bp");
        check("bp_valid_drop", {31'd0, out_valid}, 32'd0);

        // Transfer, handshake and new bit all on one edge.
        out_ready = 1'b0;
        ovr_cycles = 0;
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'hFF);
        for (int i = 0; i < 16; i++) send_pair(1'b1, 1'b0);
        repeat (3) tick();
        send_sample(1'b1);
        raw_bit = 1'b0;
        repeat (3) tick();
        out_ready = 1'b1;
        sample_tick = ~sample_tick;
        tick();
        check("sim_valid",   {31'd0, out_valid}, 32'd1);
        check("sim_data",    {24'd0, out_data}, 32'hFF);
        check("sim_count",   {28'd0, dut.count_q}, 32'd1);
        check("sim_overrun", {31'd0, overrun}, 32'd0);
        exp_q.push_back(8'hFF);
        for (int i = 0; i < 7; i++) send_pair(1'b1, 1'b0);
        drain("sim");
        check("sim_overrun_cycles", ovr_cycles, 0);

`ifdef TRNG_RCT_EN
        rst = 1'b1;
        sample_tick = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        out_ready = 1'b1;
        for (int i = 0; i < 31; i++) send_sample(1'b1);
        check("rct_before_limit", {31'd0, rct_fail}, 32'd0);
        send_sample(1'b1);
        check("rct_at_limit", {31'd0, rct_fail}, 32'd1);
        valid_cycles = 0;
        for (int i = 0; i < 8; i++) send_pair(1'b1, 1'b0);
        repeat (5) tick();
        check("rct_no_output", valid_cycles, 0);
        check("rct_sticky", {31'd0, rct_fail}, 32'd1);
        rst = 1'b1;
        tick();
        check("rct_cleared", {31'd0, rct_fail}, 32'd0);
        rst = 1'b0;
        tick();
`else
        check("rct_tied_low", {31'd0, rct_fail}, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/trng_sampler.md
Name: trng_sampler

Overview:
- Consumes the divided sample strobe from the frequency divider.
- On every strobe event, samples the asynchronous ring-oscillator entropy bit and removes bias with a Von Neumann corrector.
- Packs the debiased bits into WIDTH-bit words and offers them downstream on a valid/ready handshake.
- Sits between the divider and the TRNG output register/bus interface.

Parameters:
- WIDTH, 8, output word width in bits (>=2).
- SYNC_STAGES, 2, flops in the raw_bit synchronizer (>=2).
- RCT_LIMIT, 32, repetition-count threshold for the health test (only used when TRNG_RCT_EN is defined).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous and active-high.
- sample_tick  in  1  divider output, synchronous to clk; each toggle is one sample event.
- raw_bit  in  1  entropy source bit, asynchronous to clk.
- out_ready  in  1  downstream accepts a word.
- out_data  out  WIDTH  assembled random word.
- out_valid  out  1  out_data holds an unconsumed word.
- overrun  out  1  one-cycle pulse when a debiased bit is dropped.
- rct_fail  out  1  sticky health-test failure.

Behaviour:
- Reset: every register clears asynchronously on rst=1.
  - Outputs: out_data=0, out_valid=0, overrun=0, rct_fail=0.
  - Internal: tick_q=0, synchronizer=0, VN state=VN_IDLE, shift register=0, count=0, RCT counter=0.
  - A reset mid-word discards the partial word and any pending VN first bit.
- Sample event:
  - tick_q registers sample_tick; event = sample_tick XOR tick_q.
  - Both rising and falling toggles count as events.
  - raw_bit passes through SYNC_STAGES flops; the event samples the last stage (s_bit).
- Von Neumann FSM, states VN_IDLE and VN_HAVE_FIRST:
  - VN_IDLE + event: store s_bit as first, go to VN_HAVE_FIRST.
  - VN_HAVE_FIRST + event: if s_bit != first, emit debiased bit = first (pair 10 -> 1, pair 01 -> 0); otherwise emit nothing. Return to VN_IDLE.
  - No event: hold state.
  - The debiased bit is produced combinationally on the second event cycle and enters the shift register on that same edge.
- Packing:
  - Shift register shifts left with the new bit into the LSB, so the first bit of a word ends in the MSB.
  - count runs 0..WIDTH.
  - A bit is accepted if count<WIDTH, or if count==WIDTH and a transfer happens this cycle; in the transfer case it becomes bit 0 of the next word and count becomes 1.
  - Transfer occurs when count==WIDTH and (!out_valid or out_ready). On transfer: out_data<=shift, out_valid<=1, count<=0 (or 1 per the rule above).
  - Latency: one cycle from completing the word to out_valid.
- Handshake:
  - out_valid, once high, stays high with out_data stable until out_ready=1.
  - out_ready=1 with no transfer: out_valid<=0.
  - out_ready=1 with a same-cycle transfer: out_valid stays 1 and the new word replaces the old.
  - out_ready while out_valid=0 is ignored.
- Overrun:
  - A debiased bit arriving while count==WIDTH and no transfer occurs is dropped.
  - overrun pulses high for exactly one cycle; the shift register is unchanged.
- No arithmetic beyond the counters. count is $clog2(WIDTH+1) bits and never wraps.

Optional Feature:
- Macro: TRNG_RCT_EN.
- Defined:
  - A repetition-count health test runs on raw s_bit samples at every event, independent of the VN decision.
  - The counter resets to 1 when s_bit differs from the previous sample and increments when equal, saturating at RCT_LIMIT.
  - On reaching RCT_LIMIT, rct_fail is set and stays set until rst.
  - While rct_fail=1, no new words transfer to the output.
- Undefined: rct_fail is tied to 0 and no counter logic is present.

Decomposition:
- Package trng_pkg:
  - VN state enum (VN_IDLE, VN_HAVE_FIRST).
  - Default constants TRNG_WIDTH=8, TRNG_SYNC_STAGES=2, TRNG_RCT_LIMIT=32.
- One sub-module, bit_sync: parameterised SYNC_STAGES flop chain with async active-high reset, instantiated for raw_bit.
- VN FSM, packer and RCT stay in trng_sampler.

Test Plan:
- Reset: assert rst mid-word after 5 debiased bits, release, then feed 8 fresh pairs -> first word contains only post-reset bits; all outputs were 0 during reset.
- Debias/pack:
  - Stimulus: toggle sample_tick with raw_bit pairs 10,01,10,10,01,01,01,10, out_ready=1.
  - Required: out_data=8'hB1, out_valid high exactly one cycle.
- Discard: pairs 00,11,00,11 then 8 pairs of 10 -> single word 8'hFF; no word from the equal pairs.
- Backpressure/overrun:
  - Stimulus: out_ready=0; deliver 16 debiased 1s, then 1 more debiased bit.
  - Required: first word stays 8'hFF on the output; second word sits complete in the shift register; the 17th bit produces a 1-cycle overrun pulse.
  - Then raise out_ready -> second word 8'hFF appears the next cycle.
- Simultaneous events: out_ready=1 on the same cycle a full word transfers and a new debiased bit arrives -> out_valid stays 1, new word loads, new bit counted (count=1), no overrun.
- RCT (TRNG_RCT_EN defined, RCT_LIMIT=32): 32 consecutive events with raw_bit=1 -> rct_fail=1 after the 32nd event, sticky, no further out_valid; rst clears it.
